// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - decode/EX/MEM facing bundle of the execute stage
interface ex_stage_if;
  logic [163:0] id_to_ex_bus;
  logic [80:0]  ex_to_mem_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         ex_we;
  logic [4:0]   ex_waddr;
  logic [31:0]  ex_wdata;
  logic         ex_ram_read;
  logic         stallreq_for_ex;
  logic [31:0]  hi_o;
  logic [31:0]  lo_o;

  // Pipeline side: supplies the decode bundle, observes everything EX produces
  modport master (
    output id_to_ex_bus,
    input  ex_to_mem_bus, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  ex_we, ex_waddr, ex_wdata, ex_ram_read, stallreq_for_ex, hi_o, lo_o
  );

  // Execute stage side
  modport slave (
    input  id_to_ex_bus,
    output ex_to_mem_bus, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output ex_we, ex_waddr, ex_wdata, ex_ram_read, stallreq_for_ex, hi_o, lo_o
  );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: input register, one-hot ALU, restoring DIVU owning HI/LO
module ex_stage #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [5:0]  stall,
  ex_stage_if.slave   bus
);

  localparam int ID_TO_EX_WD = 164;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_e;

  logic [ID_TO_EX_WD-1:0] ex_reg_q, ex_reg_d;

  // Decode bundle captured in EX; all-zero content behaves as a NOP
  logic [4:0]  mem_op;
  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  src1_sel;
  logic [3:0]  src2_sel;
  logic        ram_en, rf_we, sel_rf_res;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;

  assign mem_op     = ex_reg_q[163:159];
  assign pc         = ex_reg_q[158:127];
  assign inst       = ex_reg_q[126:95];
  assign alu_op     = ex_reg_q[94:83];
  assign src1_sel   = ex_reg_q[82:80];
  assign src2_sel   = ex_reg_q[79:76];
  assign ram_en     = ex_reg_q[75];
  assign ram_wen    = ex_reg_q[74:71];
  assign rf_we      = ex_reg_q[70];
  assign rf_waddr   = ex_reg_q[69:65];
  assign sel_rf_res = ex_reg_q[64];
  assign rdata1     = ex_reg_q[63:32];
  assign rdata2     = ex_reg_q[31:0];

  // Input register next value: flush clears, EX-stop with MEM-go inserts a bubble
  always_comb begin
    ex_reg_d = ex_reg_q;
    if (flush)                     ex_reg_d = '0;
    else if (stall[2] && !stall[3]) ex_reg_d = '0;
    else if (!stall[2])            ex_reg_d = bus.id_to_ex_bus;
  end

  // Input register
  always_ff @(posedge clk) begin
    if (rst) ex_reg_q <= '0;
    else     ex_reg_q <= ex_reg_d;
  end

  logic [31:0] src1, src2, ex_result;
  logic [31:0] imm_sext, imm_zext, sra_res;

  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'b0, inst[15:0]};
  assign sra_res  = $signed(src2) >>> src1[4:0];

  // Operand selection and one-hot ALU result merge
  always_comb begin
    src1 = ({32{src1_sel[0]}} & rdata1)
         | ({32{src1_sel[1]}} & pc)
         | ({32{src1_sel[2]}} & {27'b0, inst[10:6]});
    src2 = ({32{src2_sel[0]}} & rdata2)
         | ({32{src2_sel[1]}} & imm_sext)
         | ({32{src2_sel[2]}} & 32'd8)
         | ({32{src2_sel[3]}} & imm_zext);
    ex_result = ({32{alu_op[11]}} & (src1 + src2))
              | ({32{alu_op[10]}} & (src1 - src2))
              | ({32{alu_op[9]}}  & {31'b0, $signed(src1) < $signed(src2)})
              | ({32{alu_op[8]}}  & {31'b0, src1 < src2})
              | ({32{alu_op[7]}}  & (src1 & src2))
              | ({32{alu_op[6]}}  & ~(src1 | src2))
              | ({32{alu_op[5]}}  & (src1 | src2))
              | ({32{alu_op[4]}}  & (src1 ^ src2))
              | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
              | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
              | ({32{alu_op[1]}}  & sra_res)
              | ({32{alu_op[0]}}  & {src2[15:0], 16'b0});
  end

  logic is_divu, rf_we_eff;
  assign is_divu   = (inst[31:26] == 6'b0) && (inst[5:0] == 6'b011011);
  assign rf_we_eff = rf_we && !is_divu;

  // Memory request, forwarding triple and EX->MEM bundle
  always_comb begin
    bus.data_sram_en    = ram_en;
    bus.data_sram_wen   = ram_wen[0] ? 4'b1111 : 4'b0000;
    bus.data_sram_addr  = ex_result;
    bus.data_sram_wdata = rdata2;
    bus.ex_we           = rf_we_eff;
    bus.ex_waddr        = rf_waddr;
    bus.ex_wdata        = ex_result;
    bus.ex_ram_read     = ram_en && (ram_wen == 4'b0);
    bus.ex_to_mem_bus   = {mem_op, pc, ram_en, ram_wen, sel_rf_res, rf_we_eff, rf_waddr, ex_result};
  end

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quot_q, quot_d, divisor_q, divisor_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [32:0] trial, diff;
  logic        fits, last_step;
  logic [31:0] rem_step, quot_step;

  // One restoring step: shift in next dividend bit, subtract divisor if it fits
  assign trial     = {rem_q, quot_q[31]};
  assign diff      = trial - {1'b0, divisor_q};
  assign fits      = trial >= {1'b0, divisor_q};
  assign rem_step  = fits ? diff[31:0] : trial[31:0];
  assign quot_step = {quot_q[30:0], fits};
  assign last_step = (cnt_q == 6'(DIV_ITERS - 1));

  // Divider state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Divider next state; DONE lingers while EX is held so the same DIVU is not reissued
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_divu) state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (!stall[2]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Divider outputs: stall the pipe from the issue cycle through the last step
  always_comb begin
    bus.stallreq_for_ex = (state_q == BUSY) || ((state_q == IDLE) && is_divu);
  end

  // Divider datapath next values; HI/LO only written on a completed divide
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (state_q == IDLE && is_divu) begin
      cnt_d     = '0;
      rem_d     = '0;
      quot_d    = rdata1;
      divisor_d = rdata2;
    end else if (state_q == BUSY) begin
      cnt_d  = cnt_q + 6'd1;
      rem_d  = rem_step;
      quot_d = quot_step;
      if (last_step && !flush) begin
        hi_d = rem_step;
        lo_d = quot_step;
      end
    end
  end

  // Divider datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], stall[5:4], stall[1:0], diff[32]};

endmodule
